// File: rtl/lsu_pkg.sv
// Shared types, func3 size codes and access legality check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP,
        LSU_DONE
    } lsu_state_t;

    // Misaligned halfword/word, unsigned stores and unknown codes are rejected.
    function automatic logic access_illegal(input logic [2:0] func3, input logic [1:0] offset,
                                            input logic is_store);
        logic bad;
        bad = 1'b0;
        case (func3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = is_store;
            F3_H:    bad = offset[0];
            F3_HU:   bad = is_store | offset[0];
            F3_W:    bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus: request/response handshakes between the LSU (master) and memory (slave).
interface lsu_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              bus_req_valid;
    logic              bus_req_ready;
    logic              bus_req_we;
    logic [ADDR_W-1:0] bus_req_addr;
    logic [31:0]       bus_req_wdata;
    logic [3:0]        bus_req_wstrb;
    logic              bus_resp_valid;
    logic              bus_resp_ready;
    logic [31:0]       bus_resp_rdata;
    logic              bus_resp_err;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        output bus_resp_ready,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb,
        input  bus_resp_ready,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );
endinterface

// File: rtl/lsu_load_align.sv
// Load data extraction: shift the addressed lane down, then sign- or zero-extend by size.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  func3,
    output logic [31:0] rdata
);
    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    always_comb begin
        rdata = shifted;
        case (func3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'h000000, shifted[7:0]};
            F3_HU:   rdata = {16'h0000, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one data-memory bus transaction per request pulse, with lane steering,
// byte strobes, load extension and a one-cycle completion pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mem_rvalid,
    output logic              mem_finish,
    output logic              mem_err,
    lsu_if.master             bus
);
    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        func3_q, func3_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_word;
    logic [3:0]        strb;
    logic [31:0]       lane_data;

    lsu_load_align u_load_align (
        .word   (bus.bus_resp_rdata),
        .offset (addr_q[1:0]),
        .func3  (func3_q),
        .rdata  (load_word)
    );

    always_comb begin
        strb      = 4'b1111;
        lane_data = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                strb      = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                strb      = 4'b0011 << {addr_q[1], 1'b0};
                lane_data = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign bus.bus_req_we    = we_q;
    assign bus.bus_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.bus_req_wdata = lane_data;
    assign bus.bus_req_wstrb = we_q ? strb : 4'b0000;
    assign rdata             = rdata_q;
    assign mem_err           = err_q;

    always_comb begin
        state_d            = state_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        func3_d            = func3_q;
        we_d               = we_q;
        err_d              = err_q;
        rdata_d            = rdata_q;
        bus.bus_req_valid  = 1'b0;
        bus.bus_resp_ready = 1'b0;
        mem_finish         = 1'b0;
        mem_rvalid         = 1'b0;
        unique case (state_q)
            LSU_IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    func3_d = func3;
                    we_d    = mem_write;
                    err_d   = (mem_read && mem_write) |
                              access_illegal(func3, addr[1:0], mem_write);
                    rdata_d = '0;
                    state_d = LSU_REQ;
                end
            end
            LSU_REQ: begin
                // A rejected access idles here silently so its finish lands two cycles out.
                if (err_q) begin
                    state_d = LSU_DONE;
                end else begin
                    bus.bus_req_valid = 1'b1;
                    if (bus.bus_req_ready) state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                bus.bus_resp_ready = 1'b1;
                if (bus.bus_resp_valid) begin
                    err_d   = bus.bus_resp_err;
                    rdata_d = (bus.bus_resp_err || we_q) ? '0 : load_word;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                mem_finish = 1'b1;
                mem_rvalid = !we_q && !err_q;
                state_d    = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: fixed vectors, a reset-in-flight sequence and randomized accesses vs a model.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        bit          resp_err;
        int          ready_dly;
        int          resp_dly;
        bit          mid_pulse;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        int          exp_fin;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, wdata, rdata;
    logic        mem_rvalid, mem_finish, mem_err;
    logic [31:0] al_word, al_out;
    logic [1:0]  al_off;
    logic [2:0]  al_f3;
    int          n_checks = 0;
    int          n_pass = 0;
    vec_t        tbl[14];

    lsu_if #(.ADDR_W(32)) bus ();

    lsu #(.ADDR_W(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .func3      (func3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .mem_rvalid (mem_rvalid),
        .mem_finish (mem_finish),
        .mem_err    (mem_err),
        .bus        (bus)
    );

    lsu_load_align u_ref_align (
        .word   (al_word),
        .offset (al_off),
        .func3  (al_f3),
        .rdata  (al_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] ext_load(input logic [31:0] w, input int off,
                                             input logic [2:0] f3);
        logic [31:0]        s;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        s = w >> (8 * off);
        b = s[7:0];
        h = s[15:0];
        case (f3)
            3'd0:    return int'(b);
            3'd1:    return int'(h);
            3'd4:    return {24'h0, s[7:0]};
            3'd5:    return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Reference rules: legality, latency, strobes, replication and extension from scratch.
    function automatic vec_t model(input vec_t v);
        int size, off;
        bit ok;
        off  = int'(v.addr[1:0]);
        size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        ok   = (v.rd != v.wr) && (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) &&
               !(v.wr && v.f3[2]) && (off % size == 0);
        v.exp_err   = !ok || v.resp_err;
        v.exp_fin   = ok ? 3 + v.ready_dly + v.resp_dly : 2;
        v.exp_rdata = (v.exp_err || v.wr) ? 32'h0 : ext_load(v.word, off, v.f3);
        v.exp_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (v.wr && i >= off && i < off + size) v.exp_wstrb[i] = 1'b1;
            v.exp_wdata[8*i +: 8] = v.wdata[8*(i % size) +: 8];
        end
        return v;
    endfunction

    function automatic vec_t mk(input bit rd, wr, input logic [2:0] f3,
                                input logic [31:0] a, wd, w, input bit rerr,
                                input int rdly, sdly, input bit mid, eerr,
                                input logic [31:0] erd, input logic [3:0] ews,
                                input logic [31:0] ewd, input int efin);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.word = w;
        v.resp_err = rerr; v.ready_dly = rdly; v.resp_dly = sdly; v.mid_pulse = mid;
        v.exp_err = eerr; v.exp_rdata = erd; v.exp_wstrb = ews; v.exp_wdata = ewd;
        v.exp_fin = efin;
        return v;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, " req_valid"}, 32'(bus.bus_req_valid), 32'h0);
        check({tag, " resp_ready"}, 32'(bus.bus_resp_ready), 32'h0);
        check({tag, " req_we"}, 32'(bus.bus_req_we), 32'h0);
        check({tag, " req_addr"}, bus.bus_req_addr, 32'h0);
        check({tag, " req_wdata"}, bus.bus_req_wdata, 32'h0);
        check({tag, " req_wstrb"}, 32'(bus.bus_req_wstrb), 32'h0);
        check({tag, " finish"}, 32'(mem_finish), 32'h0);
        check({tag, " rvalid"}, 32'(mem_rvalid), 32'h0);
        check({tag, " err"}, 32'(mem_err), 32'h0);
        check({tag, " rdata"}, rdata, 32'h0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          c, fin_c, fin_cnt, rv_cnt, req_cnt, resp_cnt, r_wait, s_wait;
        bit          stable, on_bus, is_load, got_rv, got_err;
        logic [31:0] r_addr, r_wdata, got_rdata;
        logic [3:0]  r_wstrb;
        logic        r_we;
        c = 0; fin_c = -1; fin_cnt = 0; rv_cnt = 0; req_cnt = 0; resp_cnt = 0;
        r_wait = 0; s_wait = 0; stable = 1'b1; got_rv = 1'b0; got_err = 1'b0;
        got_rdata = 32'h0; r_addr = 32'h0; r_wdata = 32'h0; r_wstrb = 4'h0; r_we = 1'b0;
        on_bus  = v.exp_fin > 2;
        is_load = v.rd && !v.wr;
        @(negedge clk);
        mem_read = v.rd; mem_write = v.wr; func3 = v.f3; addr = v.addr; wdata = v.wdata;
        while (c < 60 && !(fin_c >= 0 && c >= fin_c + 2)) begin
            @(negedge clk);
            c++;
            if (mem_finish) begin
                fin_cnt++; fin_c = c; got_rv = mem_rvalid; got_err = mem_err; got_rdata = rdata;
            end
            if (mem_rvalid) rv_cnt++;
            mem_read  = v.mid_pulse && c == 2;
            mem_write = 1'b0;
            func3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            bus.bus_req_ready  = 1'b0;
            bus.bus_resp_valid = 1'b0;
            bus.bus_resp_rdata = $urandom;
            bus.bus_resp_err   = 1'($urandom);
            if (bus.bus_req_valid) begin
                if (req_cnt == 0) begin
                    r_addr = bus.bus_req_addr; r_wdata = bus.bus_req_wdata;
                    r_wstrb = bus.bus_req_wstrb; r_we = bus.bus_req_we;
                end else if (r_addr !== bus.bus_req_addr || r_wdata !== bus.bus_req_wdata ||
                             r_wstrb !== bus.bus_req_wstrb || r_we !== bus.bus_req_we) begin
                    stable = 1'b0;
                end
                req_cnt++;
                if (r_wait == v.ready_dly) bus.bus_req_ready = 1'b1;
                else r_wait++;
            end
            if (bus.bus_resp_ready) begin
                resp_cnt++;
                if (s_wait == v.resp_dly) begin
                    bus.bus_resp_valid = 1'b1;
                    bus.bus_resp_rdata = v.word;
                    bus.bus_resp_err   = v.resp_err;
                end else begin
                    s_wait++;
                end
            end
        end
        mem_read = 1'b0;
        check({tag, " finish_count"}, fin_cnt, 1);
        check({tag, " finish_cycle"}, fin_c, v.exp_fin);
        check({tag, " err"}, 32'(got_err), 32'(v.exp_err));
        check({tag, " rvalid"}, 32'(got_rv), 32'(is_load && !v.exp_err));
        check({tag, " rvalid_count"}, rv_cnt, (is_load && !v.exp_err) ? 1 : 0);
        check({tag, " req_cycles"}, req_cnt, on_bus ? v.ready_dly + 1 : 0);
        check({tag, " resp_cycles"}, resp_cnt, on_bus ? v.resp_dly + 1 : 0);
        check({tag, " err_held"}, 32'(mem_err), 32'(v.exp_err));
        if (is_load) begin
            check({tag, " rdata"}, got_rdata, v.exp_rdata);
            check({tag, " rdata_held"}, rdata, v.exp_rdata);
        end
        if (on_bus) begin
            check({tag, " req_stable"}, 32'(stable), 32'h1);
            check({tag, " req_addr"}, r_addr, {v.addr[31:2], 2'b00});
            check({tag, " req_we"}, 32'(r_we), 32'(v.wr));
            check({tag, " req_wstrb"}, 32'(r_wstrb), 32'(v.exp_wstrb));
            if (v.wr) check({tag, " req_wdata"}, r_wdata, v.exp_wdata);
        end
    endtask

    initial begin
        vec_t v;
        int   r;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'h0; addr = 32'h0;
        wdata = 32'h0; al_word = 32'h0; al_off = 2'h0; al_f3 = 3'h0;
        bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0;
        bus.bus_resp_rdata = 32'h0; bus.bus_resp_err = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        tbl[0]  = mk(1, 0, F3_W,  32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0,
                     0, 32'hDEAD_BEEF, 4'h0, 32'h0, 3);
        tbl[1]  = mk(1, 0, F3_B,  32'h0000_0103, 32'h0, 32'h80FF_7F01, 0, 0, 0, 0,
                     0, 32'hFFFF_FF80, 4'h0, 32'h0, 3);
        tbl[2]  = mk(1, 0, F3_BU, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 0, 0, 0, 0,
                     0, 32'h0000_0080, 4'h0, 32'h0, 3);
        tbl[3]  = mk(1, 0, F3_H,  32'h0000_0102, 32'h0, 32'h80FF_7F01, 0, 0, 0, 0,
                     0, 32'hFFFF_80FF, 4'h0, 32'h0, 3);
        tbl[4]  = mk(1, 0, F3_HU, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 0, 0, 0, 0,
                     0, 32'h0000_80FF, 4'h0, 32'h0, 3);
        tbl[5]  = mk(0, 1, F3_B,  32'h0000_0102, 32'h1234_56AB, 32'h0, 0, 0, 0, 0,
                     0, 32'h0, 4'b0100, 32'hABAB_ABAB, 3);
        tbl[6]  = mk(0, 1, F3_H,  32'h0000_0102, 32'h1234_56AB, 32'h0, 0, 0, 0, 0,
                     0, 32'h0, 4'b1100, 32'h56AB_56AB, 3);
        tbl[7]  = mk(1, 0, F3_W,  32'h0000_0100, 32'h0, 32'h1122_3344, 0, 5, 3, 1,
                     0, 32'h1122_3344, 4'h0, 32'h0, 11);
        tbl[8]  = mk(1, 0, F3_W,  32'h0000_0102, 32'h0, 32'h5555_AAAA, 0, 0, 0, 0,
                     1, 32'h0, 4'h0, 32'h0, 2);
        tbl[9]  = mk(1, 0, F3_W,  32'h0000_0104, 32'h0, 32'h7777_7777, 1, 0, 0, 0,
                     1, 32'h0, 4'h0, 32'h0, 3);
        tbl[10] = mk(1, 1, F3_W,  32'h0000_0100, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 32'h0, 4'h0, 32'h0, 2);
        tbl[11] = mk(0, 1, F3_BU, 32'h0000_0100, 32'h0000_00FF, 32'h0, 0, 0, 0, 0,
                     1, 32'h0, 4'h0, 32'h0, 2);
        tbl[12] = mk(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 0, 0,
                     1, 32'h0, 4'h0, 32'h0, 2);
        tbl[13] = mk(0, 1, F3_W,  32'h0000_0108, 32'hCAFE_F00D, 32'h0, 0, 2, 1, 0,
                     0, 32'h0, 4'b1111, 32'hCAFE_F00D, 6);
        for (int i = 0; i < 14; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while the request is being offered: everything drops, then a clean LW.
        @(negedge clk);
        mem_read = 1'b1; func3 = F3_W; addr = 32'h0000_0200;
        @(negedge clk);
        mem_read = 1'b0;
        check("rst_pre req_valid", 32'(bus.bus_req_valid), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_in_req");
        rst = 1'b0;
        run_vec(mk(1, 0, F3_W, 32'h0000_0200, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0,
                   0, 32'h0BAD_F00D, 4'h0, 32'h0, 3), "after_rst");

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 15);
            v.rd = (r == 0) ? 1'b1 : r[0];
            v.wr = (r == 0) ? 1'b1 : !r[0];
            v.f3 = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 2)) :
                                                 3'($urandom_range(0, 7));
            v.addr = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wdata = $urandom; v.word = $urandom;
            v.resp_err  = ($urandom_range(0, 7) == 0);
            v.ready_dly = $urandom_range(0, 3);
            v.resp_dly  = $urandom_range(0, 3);
            v.mid_pulse = ($urandom_range(0, 3) == 0);
            v = model(v);
            run_vec(v, $sformatf("rnd%0d", i));
            al_word = v.word; al_off = v.addr[1:0]; al_f3 = v.f3;
            #1;
            check($sformatf("rnd%0d align", i), al_out, ext_load(v.word, int'(v.addr[1:0]), v.f3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
